// File: rtl/regfile_access_ctrl_pkg.sv
// rf_ctrl_pkg: shared constants and FSM state type for the register file access controller
package rf_ctrl_pkg;
  localparam int XLEN = 32;
  localparam int ADDR_W = 5;
  localparam logic [ADDR_W-1:0] REG_ZERO = '0;
  localparam logic [ADDR_W-1:0] REG_LAST = '1;
  typedef enum logic {IDLE, CLEAR} state_e;
endpackage

// File: rtl/regfile_access_ctrl_if.sv
// regfile_access_ctrl_if: core, debug, clear and register file port signals of the access controller
interface regfile_access_ctrl_if #(
  parameter int XLEN = 32,
  parameter int ADDR_W = 5
);
  logic              core_we;
  logic [ADDR_W-1:0] core_waddr;
  logic [XLEN-1:0]   core_wdata;
  logic              core_rb_en;
  logic [ADDR_W-1:0] core_raddr_b;
  logic              core_stall;
  logic              dbg_req_valid;
  logic              dbg_req_ready;
  logic              dbg_req_write;
  logic [ADDR_W-1:0] dbg_req_addr;
  logic [XLEN-1:0]   dbg_req_wdata;
  logic              dbg_rsp_valid;
  logic [XLEN-1:0]   dbg_rsp_rdata;
  logic              clr_start;
  logic              clr_busy;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_waddr;
  logic [XLEN-1:0]   rf_wdata;
  logic [ADDR_W-1:0] rf_raddr_b;
  logic [XLEN-1:0]   rf_rdata_b;
  modport slave (
    input  core_we, core_waddr, core_wdata, core_rb_en, core_raddr_b,
    input  dbg_req_valid, dbg_req_write, dbg_req_addr, dbg_req_wdata,
    input  clr_start, rf_rdata_b,
    output core_stall, dbg_req_ready, dbg_rsp_valid, dbg_rsp_rdata,
    output clr_busy, rf_we, rf_waddr, rf_wdata, rf_raddr_b
  );
  modport master (
    output core_we, core_waddr, core_wdata, core_rb_en, core_raddr_b,
    output dbg_req_valid, dbg_req_write, dbg_req_addr, dbg_req_wdata,
    output clr_start, rf_rdata_b,
    input  core_stall, dbg_req_ready, dbg_rsp_valid, dbg_rsp_rdata,
    input  clr_busy, rf_we, rf_waddr, rf_wdata, rf_raddr_b
  );
endinterface

// File: rtl/regfile_access_ctrl.sv
// regfile_access_ctrl: arbitrates the register file write port and read port B between core and debug, and runs the x1..x31 clear sequence
module regfile_access_ctrl #(
  parameter int XLEN = rf_ctrl_pkg::XLEN,
  parameter int ADDR_W = rf_ctrl_pkg::ADDR_W,
  parameter int STARVE_LIMIT = 8
) (
  input logic clk,
  input logic reset,
  regfile_access_ctrl_if.slave bus
);
  import rf_ctrl_pkg::*;
  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);
  state_e            state_q, state_d;
  logic [7:0]        starve_q, starve_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic              rsp_valid_q;
  logic [XLEN-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic              clearing, conflict, grant, dbg_wr, dbg_rd, addr_nz;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      starve_q    <= '0;
      clr_cnt_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      clr_cnt_q   <= clr_cnt_d;
      rsp_valid_q <= grant;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end
  always_comb begin
    clearing    = state_q == CLEAR;
    conflict    = bus.dbg_req_write ? bus.core_we : bus.core_rb_en;
    grant       = !reset && !clearing && !bus.clr_start && bus.dbg_req_valid && (!conflict || starve_q == LIMIT);
    dbg_wr      = grant && bus.dbg_req_write;
    dbg_rd      = grant && !bus.dbg_req_write;
    addr_nz     = bus.dbg_req_addr != REG_ZERO;
    state_d     = clearing ? (clr_cnt_q == REG_LAST ? IDLE : CLEAR) : (bus.clr_start ? CLEAR : IDLE);
    clr_cnt_d   = state_d == IDLE ? '0 : clearing ? clr_cnt_q + 1'b1 : ADDR_W'(1);
    starve_d    = (!bus.dbg_req_valid || grant) ? '0 : starve_q == LIMIT ? LIMIT : starve_q + 8'd1;
    rsp_rdata_d = (dbg_rd && addr_nz) ? bus.rf_rdata_b : '0;
  end
  // writes are held off while reset is asserted so an interrupted clear leaves the remaining registers untouched
  assign bus.rf_we         = !reset && (clearing || (dbg_wr ? addr_nz : bus.core_we));
  assign bus.rf_waddr      = clearing ? clr_cnt_q : dbg_wr ? bus.dbg_req_addr : bus.core_waddr;
  assign bus.rf_wdata      = clearing ? '0 : dbg_wr ? bus.dbg_req_wdata : bus.core_wdata;
  assign bus.rf_raddr_b    = dbg_rd ? bus.dbg_req_addr : bus.core_raddr_b;
  assign bus.core_stall    = clearing || (grant && conflict);
  assign bus.dbg_req_ready = grant;
  assign bus.clr_busy      = clearing;
  assign bus.dbg_rsp_valid = rsp_valid_q;
  assign bus.dbg_rsp_rdata = rsp_rdata_q;
endmodule
